// File: rtl/atmega_pll_ctrl_if.sv
// -----------------------------------------------------------------------------
// atmega_pll_ctrl_if
// CPU I/O bus bundle for the PLL controller register file.
//   addr_dat    : byte address on the I/O bus
//   wr_dat      : write strobe, data taken from bus_dat_in on the rising clk edge
//   rd_dat      : read strobe, bus_dat_out is valid combinationally while high
//   bus_dat_in  : write data
//   bus_dat_out : read data, 0 unless rd_dat=1 and a register is addressed
// Modports: master = CPU side, slave = register block side.
// -----------------------------------------------------------------------------
interface atmega_pll_ctrl_if #(
  parameter int unsigned BUS_ADDR_DATA_LEN = 16
);
  logic [BUS_ADDR_DATA_LEN-1:0] addr_dat;
  logic                         wr_dat;
  logic                         rd_dat;
  logic [7:0]                   bus_dat_in;
  logic [7:0]                   bus_dat_out;

  modport master (
    output addr_dat,
    output wr_dat,
    output rd_dat,
    output bus_dat_in,
    input  bus_dat_out
  );

  modport slave (
    input  addr_dat,
    input  wr_dat,
    input  rd_dat,
    input  bus_dat_in,
    output bus_dat_out
  );
endinterface

// File: rtl/atmega_pll_ctrl.sv
// -----------------------------------------------------------------------------
// atmega_pll_ctrl
// Owns PLLCSR/PLLFRQ and sequences the PLL clock generator: OFF -> LOCKING ->
// LOCKED, with a cycle counter standing in for lock acquisition. Downstream
// PLL clocks are gated until lock, and the applied frequency configuration
// only ever changes while the gate is closed.
//
// Ports:
//   clk, rst       : clock and asynchronous active-high reset
//   bus (slave)    : CPU I/O bus (addr_dat, wr_dat, rd_dat, bus_dat_in, bus_dat_out)
//   pll_frq_cfg    : PLLFRQ value currently applied to the prescaler datapath
//   pll_run        : PLL datapath counter enable
//   pll_clk_gate   : 1 = PLL-derived clocks usable downstream
//   pll_locked     : lock flag, same value as PLLCSR.PLOCK
//
// Build option ATMEGA_PLL_CTRL_RELOCK_EN:
//   defined   : a frequency change while LOCKED drops lock, drains for
//               SETTLE_CYCLES, applies the new value and relocks.
//   undefined : no DRAIN state; a new PLLFRQ is applied only in OFF, so it
//               takes effect after PLLE is cycled 1 -> 0 -> 1.
// -----------------------------------------------------------------------------
module atmega_pll_ctrl #(
  parameter int unsigned BUS_ADDR_DATA_LEN = 16,
  parameter int unsigned PLLCSR_ADDR       = 'h49,
  parameter int unsigned PLLFRQ_ADDR       = 'h52,
  parameter int unsigned LOCK_CYCLES       = 1024,
  parameter int unsigned SETTLE_CYCLES     = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  atmega_pll_ctrl_if.slave        bus,
  output logic [7:0]              pll_frq_cfg,
  output logic                    pll_run,
  output logic                    pll_clk_gate,
  output logic                    pll_locked
);

  localparam int unsigned MAX_CYC = (LOCK_CYCLES > SETTLE_CYCLES) ? LOCK_CYCLES : SETTLE_CYCLES;
  // Guard against a zero-width counter when both cycle counts are 1.
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] LOCK_LOAD = CNT_W'(LOCK_CYCLES - 1);
`ifdef ATMEGA_PLL_CTRL_RELOCK_EN
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
`endif

  localparam logic [BUS_ADDR_DATA_LEN-1:0] CSR_A = BUS_ADDR_DATA_LEN'(PLLCSR_ADDR);
  localparam logic [BUS_ADDR_DATA_LEN-1:0] FRQ_A = BUS_ADDR_DATA_LEN'(PLLFRQ_ADDR);

  typedef enum logic [1:0] {
    ST_OFF     = 2'd0,
    ST_LOCKING = 2'd1,
    ST_LOCKED  = 2'd2
`ifdef ATMEGA_PLL_CTRL_RELOCK_EN
    ,
    ST_DRAIN   = 2'd3
`endif
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       cfg_q, cfg_d;
  logic [7:0]       pllfrq_q, pllfrq_d;
  logic             pindiv_q, pindiv_d;
  logic             plle_q, plle_d;
`ifdef ATMEGA_PLL_CTRL_RELOCK_EN
  logic             frq_chg_q, frq_chg_d;
`endif

  logic csr_sel, frq_sel, wr_csr, wr_frq;
  logic run, gate, plock;

  assign csr_sel = (bus.addr_dat == CSR_A);
  assign frq_sel = (bus.addr_dat == FRQ_A);
  assign wr_csr  = bus.wr_dat & csr_sel;
  assign wr_frq  = bus.wr_dat & frq_sel;

  // Register file write path. PLOCK and the reserved PLLCSR bits have no
  // storage; they are synthesised on readback.
  always_comb begin
    pindiv_d = pindiv_q;
    plle_d   = plle_q;
    pllfrq_d = pllfrq_q;
    if (wr_csr) begin
      pindiv_d = bus.bus_dat_in[4];
      plle_d   = bus.bus_dat_in[1];
    end
    if (wr_frq) begin
      pllfrq_d = bus.bus_dat_in;
    end
  end

`ifdef ATMEGA_PLL_CTRL_RELOCK_EN
  // One-cycle flag: a PLLFRQ write just landed with a value different from the
  // applied one. Only LOCKED acts on it; writes seen in other states leave just
  // the shadow updated, to be picked up at the next DRAIN exit or in OFF.
  assign frq_chg_d = wr_frq & (bus.bus_dat_in != cfg_q);
`endif

  // Read mux is combinational so the CPU sees PLOCK in the same cycle as
  // pll_locked.
  always_comb begin
    bus.bus_dat_out = 8'h00;
    if (bus.rd_dat) begin
      if (csr_sel) begin
        bus.bus_dat_out = {3'b000, pindiv_q, 2'b00, plle_q, plock};
      end else if (frq_sel) begin
        bus.bus_dat_out = pllfrq_q;
      end
    end
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cfg_d   = cfg_q;
    run     = 1'b0;
    gate    = 1'b0;
    plock   = 1'b0;

    unique case (state_q)
      ST_OFF: begin
        // Gate is closed, so the shadow may be applied freely.
        cfg_d = pllfrq_q;
        if (plle_q) begin
          state_d = ST_LOCKING;
          cnt_d   = LOCK_LOAD;
        end
      end

      ST_LOCKING: begin
        run = 1'b1;
        if (cnt_q == '0) begin
          state_d = ST_LOCKED;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_LOCKED: begin
        run   = 1'b1;
        gate  = 1'b1;
        plock = 1'b1;
`ifdef ATMEGA_PLL_CTRL_RELOCK_EN
        if (frq_chg_q) begin
          state_d = ST_DRAIN;
          cnt_d   = SETTLE_LOAD;
        end
`endif
      end

`ifdef ATMEGA_PLL_CTRL_RELOCK_EN
      ST_DRAIN: begin
        // Gate already closed for SETTLE_CYCLES before cfg moves.
        run = 1'b1;
        if (cnt_q == '0) begin
          cfg_d   = pllfrq_q;
          state_d = ST_LOCKING;
          cnt_d   = LOCK_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
`endif

      default: begin
        state_d = ST_OFF;
        cnt_d   = '0;
      end
    endcase

    // Disabling the PLL overrides every other transition, including a
    // pending DRAIN exit, so cfg holds until OFF reapplies the shadow.
    if ((state_q != ST_OFF) && !plle_q) begin
      state_d = ST_OFF;
      cnt_d   = '0;
      cfg_d   = cfg_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_OFF;
      cnt_q     <= '0;
      cfg_q     <= 8'h00;
      pllfrq_q  <= 8'h00;
      pindiv_q  <= 1'b0;
      plle_q    <= 1'b0;
`ifdef ATMEGA_PLL_CTRL_RELOCK_EN
      frq_chg_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cfg_q     <= cfg_d;
      pllfrq_q  <= pllfrq_d;
      pindiv_q  <= pindiv_d;
      plle_q    <= plle_d;
`ifdef ATMEGA_PLL_CTRL_RELOCK_EN
      frq_chg_q <= frq_chg_d;
`endif
    end
  end

  assign pll_frq_cfg  = cfg_q;
  assign pll_run      = run;
  assign pll_clk_gate = gate;
  assign pll_locked   = plock;

endmodule

// File: tb/tb_atmega_pll_ctrl.sv
// -----------------------------------------------------------------------------
// tb_atmega_pll_ctrl
// Directed bench for atmega_pll_ctrl with LOCK_CYCLES=8, SETTLE_CYCLES=4.
// Inputs change 1ns after a rising edge or on the falling edge; outputs are
// sampled 1ns after the rising edge. Honours ATMEGA_PLL_CTRL_RELOCK_EN.
// -----------------------------------------------------------------------------
module tb_atmega_pll_ctrl;
  localparam int LC = 8;
  localparam int SC = 4;
  localparam logic [15:0] CSR = 16'h0049;
  localparam logic [15:0] FRQ = 16'h0052;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] cfg;
  logic       run, gate, locked;
  logic [7:0] rd;
  int         checks = 0;
  int         errors = 0;

  atmega_pll_ctrl_if #(.BUS_ADDR_DATA_LEN(16)) bus_if ();

  atmega_pll_ctrl #(
    .BUS_ADDR_DATA_LEN(16),
    .PLLCSR_ADDR('h49),
    .PLLFRQ_ADDR('h52),
    .LOCK_CYCLES(LC),
    .SETTLE_CYCLES(SC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if.slave),
    .pll_frq_cfg(cfg),
    .pll_run(run),
    .pll_clk_gate(gate),
    .pll_locked(locked)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Write lands on the rising edge this task waits for; returns 1ns after it.
  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    bus_if.addr_dat   = a;
    bus_if.bus_dat_in = d;
    bus_if.wr_dat     = 1'b1;
    @(posedge clk);
    #1;
    bus_if.wr_dat = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [7:0] d);
    bus_if.addr_dat = a;
    bus_if.rd_dat   = 1'b1;
    #1;
    d = bus_if.bus_dat_out;
    bus_if.rd_dat = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    checks++; if ({run, gate, locked} !== 3'b000) begin errors++; $display("FAIL rst_outs: got %b want 000", {run, gate, locked}); end
    checks++; if (cfg !== 8'h00) begin errors++; $display("FAIL rst_cfg: got %h want 00", cfg); end
    bus_read(CSR, rd);
    checks++; if (rd !== 8'h00) begin errors++; $display("FAIL rst_csr: got %h want 00", rd); end
    bus_read(FRQ, rd);
    checks++; if (rd !== 8'h00) begin errors++; $display("FAIL rst_frq: got %h want 00", rd); end
    @(negedge clk);
    rst = 1'b0;
    tick(1);
    checks++; if ({run, gate, locked} !== 3'b000) begin errors++; $display("FAIL idle_outs: got %b want 000", {run, gate, locked}); end
  endtask

  task automatic test_lock();
    bus_write(FRQ, 8'h4A);
    bus_write(CSR, 8'h12);       // edge N
    checks++; if (cfg !== 8'h4A) begin errors++; $display("FAIL lock_cfg_n: got %h want 4a", cfg); end
    tick(1);                     // N+1
    checks++; if ({run, gate, locked} !== 3'b100) begin errors++; $display("FAIL lock_n1: got %b want 100", {run, gate, locked}); end
    tick(LC - 1);                // N+8
    checks++; if ({run, gate, locked} !== 3'b100) begin errors++; $display("FAIL lock_n8: got %b want 100", {run, gate, locked}); end
    bus_read(CSR, rd);
    checks++; if (rd !== 8'h12) begin errors++; $display("FAIL lock_csr_n8: got %h want 12", rd); end
    tick(1);                     // N+9
    checks++; if ({run, gate, locked} !== 3'b111) begin errors++; $display("FAIL lock_n9: got %b want 111", {run, gate, locked}); end
    bus_read(CSR, rd);
    checks++; if (rd !== 8'h13) begin errors++; $display("FAIL lock_csr_n9: got %h want 13", rd); end
    bus_read(FRQ, rd);
    checks++; if (rd !== 8'h4A) begin errors++; $display("FAIL lock_frq: got %h want 4a", rd); end
    checks++; if (cfg !== 8'h4A) begin errors++; $display("FAIL lock_cfg_n9: got %h want 4a", cfg); end
    bus_if.addr_dat = CSR;
    bus_if.rd_dat   = 1'b0;
    #1;
    checks++; if (bus_if.bus_dat_out !== 8'h00) begin errors++; $display("FAIL rd_low: got %h want 00", bus_if.bus_dat_out); end
  endtask

  task automatic test_plle_off();
    bus_write(CSR, 8'h00);       // edge N
    tick(1);
    checks++; if ({run, gate, locked} !== 3'b000) begin errors++; $display("FAIL off_outs: got %b want 000", {run, gate, locked}); end
    bus_read(CSR, rd);
    checks++; if (rd !== 8'h00) begin errors++; $display("FAIL off_csr: got %h want 00", rd); end
    bus_write(CSR, 8'hFF);       // edge M
    bus_read(CSR, rd);
    checks++; if (rd !== 8'h12) begin errors++; $display("FAIL ff_csr_m: got %h want 12", rd); end
    tick(LC);                    // M+8
    bus_read(CSR, rd);
    checks++; if (rd !== 8'h12) begin errors++; $display("FAIL ff_csr_m8: got %h want 12", rd); end
    tick(1);                     // M+9
    bus_read(CSR, rd);
    checks++; if (rd !== 8'h13) begin errors++; $display("FAIL ff_csr_m9: got %h want 13", rd); end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL ff_locked: got %b want 1", locked); end
  endtask

`ifdef ATMEGA_PLL_CTRL_RELOCK_EN
  task automatic test_relock();
    bus_write(FRQ, 8'h48);       // edge N
    tick(1);                     // N+1
    checks++; if ({run, gate, locked} !== 3'b100) begin errors++; $display("FAIL rl_n1: got %b want 100", {run, gate, locked}); end
    checks++; if (cfg !== 8'h4A) begin errors++; $display("FAIL rl_cfg_n1: got %h want 4a", cfg); end
    tick(SC - 1);                // N+4
    checks++; if (cfg !== 8'h4A) begin errors++; $display("FAIL rl_cfg_n4: got %h want 4a", cfg); end
    tick(1);                     // N+5
    checks++; if (cfg !== 8'h48) begin errors++; $display("FAIL rl_cfg_n5: got %h want 48", cfg); end
    checks++; if (gate !== 1'b0) begin errors++; $display("FAIL rl_gate_n5: got %b want 0", gate); end
    tick(LC - 1);                // N+12
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL rl_lock_n12: got %b want 0", locked); end
    tick(1);                     // N+13
    checks++; if ({run, gate, locked} !== 3'b111) begin errors++; $display("FAIL rl_n13: got %b want 111", {run, gate, locked}); end
    bus_write(FRQ, 8'h48);       // unchanged value
    tick(1);
    checks++; if (gate !== 1'b1) begin errors++; $display("FAIL same_gate1: got %b want 1", gate); end
    tick(5);
    checks++; if ({gate, locked} !== 2'b11) begin errors++; $display("FAIL same_gate6: got %b want 11", {gate, locked}); end
  endtask

  task automatic test_drain_abort();
    bus_write(FRQ, 8'h55);       // edge N
    tick(2);                     // N+2, in DRAIN
    checks++; if ({run, gate, locked} !== 3'b100) begin errors++; $display("FAIL dr_state: got %b want 100", {run, gate, locked}); end
    bus_write(CSR, 8'h10);       // edge N+3
    tick(1);                     // N+4, OFF
    checks++; if ({run, gate, locked} !== 3'b000) begin errors++; $display("FAIL dr_off: got %b want 000", {run, gate, locked}); end
    tick(1);                     // N+5, OFF has reapplied the shadow
    checks++; if (cfg !== 8'h55) begin errors++; $display("FAIL dr_cfg: got %h want 55", cfg); end
  endtask
`else
  task automatic test_norelock();
    bus_write(FRQ, 8'h48);
    tick(1);
    checks++; if ({gate, locked} !== 2'b11) begin errors++; $display("FAIL nr_gate1: got %b want 11", {gate, locked}); end
    checks++; if (cfg !== 8'h4A) begin errors++; $display("FAIL nr_cfg1: got %h want 4a", cfg); end
    tick(SC + LC);
    checks++; if (gate !== 1'b1) begin errors++; $display("FAIL nr_gate12: got %b want 1", gate); end
    checks++; if (cfg !== 8'h4A) begin errors++; $display("FAIL nr_cfg12: got %h want 4a", cfg); end
    bus_read(FRQ, rd);
    checks++; if (rd !== 8'h48) begin errors++; $display("FAIL nr_frq: got %h want 48", rd); end
    bus_write(CSR, 8'h00);       // edge M
    tick(2);                     // M+2
    checks++; if (cfg !== 8'h48) begin errors++; $display("FAIL nr_cfg_off: got %h want 48", cfg); end
    bus_write(CSR, 8'h02);
    tick(LC + 1);
    checks++; if ({run, gate, locked} !== 3'b111) begin errors++; $display("FAIL nr_relock: got %b want 111", {run, gate, locked}); end
    checks++; if (cfg !== 8'h48) begin errors++; $display("FAIL nr_cfg_lock: got %h want 48", cfg); end
  endtask
`endif

  task automatic test_reset_mid();
    bus_write(CSR, 8'h00);
    tick(1);
    bus_write(CSR, 8'h02);       // edge N
    tick(3);                     // N+3, LOCKING
    checks++; if ({run, gate} !== 2'b10) begin errors++; $display("FAIL mid_lockg: got %b want 10", {run, gate}); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if ({run, gate, locked} !== 3'b000) begin errors++; $display("FAIL mid_rst_outs: got %b want 000", {run, gate, locked}); end
    checks++; if (cfg !== 8'h00) begin errors++; $display("FAIL mid_rst_cfg: got %h want 00", cfg); end
    bus_read(CSR, rd);
    checks++; if (rd !== 8'h00) begin errors++; $display("FAIL mid_rst_csr: got %h want 00", rd); end
    bus_read(FRQ, rd);
    checks++; if (rd !== 8'h00) begin errors++; $display("FAIL mid_rst_frq: got %h want 00", rd); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bus_if.addr_dat   = '0;
    bus_if.wr_dat     = 1'b0;
    bus_if.rd_dat     = 1'b0;
    bus_if.bus_dat_in = 8'h00;
    test_reset();
    test_lock();
    test_plle_off();
`ifdef ATMEGA_PLL_CTRL_RELOCK_EN
    test_relock();
    test_drain_abort();
`else
    test_norelock();
`endif
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
